flit_injector: RTL and testbench

//  Network-interface transmitter on a router input port (L port by default): the requesting side of the 5-port arbiter.

---
 rtl/noc_pkg.sv | 19 +
 rtl/inj_budget_calc.sv | 22 ++
 rtl/flit_injector.sv | 192 +++++++++++++++++++
 tb/tb_flit_injector.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, router port indices, default length width.
package noc_pkg;

  localparam logic [2:0] FLIT_IDLE = 3'b000;
  localparam logic [2:0] FLIT_HEAD = 3'b110;
  localparam logic [2:0] FLIT_BODY = 3'b100;
  localparam logic [2:0] FLIT_TAIL = 3'b101;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_S = 3'd4
  } port_e;

  localparam int NOC_LEN_W = 12;

endpackage

// File: rtl/inj_budget_calc.sv
// Timer budget for the arbiter: remaining flits, plus the header if still unsent,
// plus slack, saturated to the timer width.
module inj_budget_calc #(
  parameter int LEN_W = 12,
  parameter int SLACK = 4
) (
  input  logic [LEN_W-1:0] rem,
  input  logic             hdr_pending,
  output logic [LEN_W-1:0] length
);

  localparam longint unsigned LEN_MAX = (64'd1 << LEN_W) - 64'd1;

  function automatic logic [LEN_W-1:0] sat_len(input longint unsigned sum);
    return (sum > LEN_MAX) ? '1 : sum[LEN_W-1:0];
  endfunction

  always_comb begin
    length = sat_len(64'(rem) + 64'(hdr_pending) + 64'(SLACK));
  end

endmodule

// File: rtl/flit_injector.sv
// Network-interface transmitter: requests the router arbiter, streams header and payload
// flits while granted, stalls and re-requests on grant loss. Define INJ_STATS_EN for counters.
module flit_injector
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = NOC_LEN_W,
  parameter int DEST_W = 4,
  parameter int SLACK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [DEST_W-1:0] pkt_dest,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  output logic              flit_valid,
  output logic [DATA_W-1:0] flit_data
`ifdef INJ_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       preempt_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HEAD,
    S_BODY,
    S_WAIT,
    S_REL
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                hdr_q, hdr_d;
  logic                live_q;
  logic                req_d;
  logic [2:0]          id_d;
  logic [LEN_W-1:0]    length_d;
  logic                fv_d;
  logic [DATA_W-1:0]   fd_d;
  logic [LEN_W-1:0]    bud_rem;
  logic                bud_hdr;
  logic [LEN_W-1:0]    budget;
  logic [DATA_W-1:0]   hdr_word;

  // live_q keeps pkt_ready low for the first cycle after reset release
  assign pkt_ready = live_q && (state_q == S_IDLE);
  assign pl_ready  = (state_q == S_BODY) && grant;

  // In S_IDLE the budget is for the incoming descriptor, header included
  assign bud_rem = (state_q == S_IDLE) ? pkt_len : rem_q;
  assign bud_hdr = (state_q == S_IDLE) || hdr_q;

  inj_budget_calc #(
    .LEN_W (LEN_W),
    .SLACK (SLACK)
  ) u_budget (
    .rem         (bud_rem),
    .hdr_pending (bud_hdr),
    .length      (budget)
  );

  always_comb begin
    hdr_word = '0;
    hdr_word[DEST_W+LEN_W-1:0] = {dest_q, len_q};
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    hdr_d    = hdr_q;
    dest_d   = dest_q;
    len_d    = len_q;
    req_d    = req;
    id_d     = flit_id;
    length_d = length;
    fv_d     = 1'b0;
    fd_d     = flit_data;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid && pkt_ready) begin
          dest_d   = pkt_dest;
          len_d    = pkt_len;
          rem_d    = pkt_len;
          hdr_d    = 1'b1;
          req_d    = 1'b1;
          id_d     = FLIT_HEAD;
          length_d = budget;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (grant) state_d = S_HEAD;
      end
      S_HEAD: begin
        if (grant) begin
          fv_d    = 1'b1;
          id_d    = FLIT_HEAD;
          fd_d    = hdr_word;
          hdr_d   = 1'b0;
          state_d = (rem_q == '0) ? S_REL : S_BODY;
        end else begin
          length_d = budget;
          state_d  = S_WAIT;
        end
      end
      S_BODY: begin
        if (!grant) begin
          id_d     = FLIT_HEAD;
          length_d = budget;
          state_d  = S_WAIT;
        end else if (pl_valid) begin
          fv_d  = 1'b1;
          fd_d  = pl_data;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            id_d    = FLIT_TAIL;
            state_d = S_REL;
          end else begin
            id_d = FLIT_BODY;
          end
        end else begin
          // bubble: must not present HEAD or the arbiter would keep reloading the timer
          id_d = FLIT_BODY;
        end
      end
      S_WAIT: begin
        if (grant) state_d = hdr_q ? S_HEAD : S_BODY;
      end
      S_REL: begin
        req_d   = 1'b0;
        id_d    = FLIT_IDLE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      hdr_q      <= 1'b0;
      live_q     <= 1'b0;
      req        <= 1'b0;
      flit_id    <= FLIT_IDLE;
      length     <= '0;
      flit_valid <= 1'b0;
      flit_data  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      hdr_q      <= hdr_d;
      live_q     <= 1'b1;
      req        <= req_d;
      flit_id    <= id_d;
      length     <= length_d;
      flit_valid <= fv_d;
      flit_data  <= fd_d;
    end
  end

  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    len_q  <= len_d;
  end

`ifdef INJ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt     <= '0;
      preempt_cnt <= '0;
    end else begin
      if (state_q == S_REL) pkt_cnt <= pkt_cnt + 16'd1;
      if (state_d == S_WAIT && state_q != S_WAIT) preempt_cnt <= preempt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: packet-level reference model (expected flit list,
// remaining-length budget) against randomized payload, stall and grant-loss patterns.
module tb_flit_injector;
  import noc_pkg::*;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 12;
  localparam int DEST_W  = 4;
  localparam int SLACK   = 4;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  typedef struct {
    logic [2:0]        id;
    logic [DATA_W-1:0] data;
  } flit_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [DEST_W-1:0] pkt_dest;
  logic [LEN_W-1:0]  pkt_len;
  logic              pl_valid;
  logic              pl_ready;
  logic [DATA_W-1:0] pl_data;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [LEN_W-1:0]  length;
  logic              flit_valid;
  logic [DATA_W-1:0] flit_data;
`ifdef INJ_STATS_EN
  logic [15:0]       pkt_cnt;
  logic [15:0]       preempt_cnt;
  int                pkts_done = 0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flit_injector #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DEST_W (DEST_W),
    .SLACK  (SLACK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dest   (pkt_dest),
    .pkt_len    (pkt_len),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .grant      (grant),
    .req        (req),
    .flit_id    (flit_id),
    .length     (length),
    .flit_valid (flit_valid),
    .flit_data  (flit_data)
`ifdef INJ_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .preempt_cnt(preempt_cnt)
`endif
  );

  function automatic logic [LEN_W-1:0] exp_budget(input int rem, input bit hdr);
    int v;
    v = rem + SLACK + (hdr ? 1 : 0);
    if (v > LEN_MAX) v = LEN_MAX;
    return LEN_W'(v);
  endfunction

  // Drives one packet through the DUT with an arbiter model that grants one cycle after
  // req, optionally withholding grant; checks every flit and the advertised budget.
  task automatic run_packet(input logic [DEST_W-1:0] dest, input int len,
                            input int drop_flits, input int drop_cyc, input int drop_len,
                            input int stall_pct, input int stall_at, input int stall_len,
                            output int span, output bit pl_seen);
    flit_t             exp_q[$];
    logic [DATA_W-1:0] payload[$];
    flit_t             f;
    logic [DATA_W-1:0] h;
    logic [LEN_W-1:0]  want_len;
    int  got, sent_pl, first_c, limit, wait_c, drop_left, stall_left;
    bit  after_tail, done, dropped, stalled, req_prev, grant_prev;

    span = -1; pl_seen = 0;
    got = 0; sent_pl = 0; first_c = 0; drop_left = 0; stall_left = 0;
    after_tail = 0; done = 0; dropped = 0; stalled = 0; req_prev = 0; grant_prev = 0;
    limit = len * 4 + 200;

    h = '0;
    h[DEST_W+LEN_W-1:0] = {dest, LEN_W'(len)};
    f.id = FLIT_HEAD; f.data = h;
    exp_q.push_back(f);
    for (int i = 0; i < len; i++) begin
      payload.push_back($urandom);
      f.id   = (i == len - 1) ? FLIT_TAIL : FLIT_BODY;
      f.data = payload[i];
      exp_q.push_back(f);
    end

    pkt_valid = 1'b1; pkt_dest = dest; pkt_len = LEN_W'(len);
    grant = 1'b0; pl_valid = 1'b0;
    wait_c = 0;
    while (!pkt_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    total++;
    if (!pkt_ready) begin
      bad++;
      $display("FAIL pkt_accept: pkt_ready=%b want 1 within 50 cycles", pkt_ready);
      pkt_valid = 1'b0;
      return;
    end
    @(negedge clk);
    pkt_valid = 1'b0;

    for (int c = 0; c < limit; c++) begin
      if (after_tail) begin
        total++;
        if ({req, flit_valid, flit_id, pkt_ready} !== {1'b0, 1'b0, FLIT_IDLE, 1'b1}) begin
          bad++;
          $display("FAIL release: req=%b flit_valid=%b flit_id=%03b pkt_ready=%b want 0 0 000 1",
                   req, flit_valid, flit_id, pkt_ready);
        end
        done = 1;
        break;
      end
      if (flit_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_flit: got id=%03b data=%08h want none", flit_id, flit_data);
        end else begin
          f = exp_q.pop_front();
          if ({flit_id, flit_data} !== {f.id, f.data}) begin
            bad++;
            $display("FAIL flit[%0d]: got id=%03b data=%08h want id=%03b data=%08h",
                     got, flit_id, flit_data, f.id, f.data);
          end
        end
        total++;
        if (!grant_prev) begin
          bad++;
          $display("FAIL flit_without_grant: flit[%0d] sent with grant=%b want 1", got, grant_prev);
        end
        if (got == 0) first_c = c;
        got++;
        if (got == len + 1) begin
          after_tail = 1;
          span = c - first_c;
        end
      end else if (req && flit_id == FLIT_HEAD) begin
        want_len = exp_budget(len - ((got > 0) ? got - 1 : 0), got == 0);
        total++;
        if (length !== want_len) begin
          bad++;
          $display("FAIL budget: length=%0d want %0d (flits sent %0d of %0d)",
                   length, want_len, got, len + 1);
        end
      end
      total++;
      if (req !== 1'b1) begin
        bad++;
        $display("FAIL req_held: req=%b want 1 during packet (flits sent %0d)", req, got);
      end

      if (!dropped && ((drop_flits >= 0 && got == drop_flits) || c == drop_cyc)) begin
        drop_left = drop_len;
        dropped   = 1;
      end
      grant = req_prev && (drop_left == 0);
      if (drop_left > 0) drop_left--;

      if (!stalled && stall_at >= 0 && sent_pl == stall_at) begin
        stall_left = stall_len;
        stalled    = 1;
      end
      pl_valid = (stall_left == 0) && (sent_pl < len) && ($urandom_range(99) >= stall_pct);
      if (stall_left > 0) stall_left--;
      pl_data = (sent_pl < len) ? payload[sent_pl] : '0;
      #1;
      if (pl_ready) pl_seen = 1;
      if (pl_valid && pl_ready) sent_pl++;
      grant_prev = grant;
      req_prev   = req;
      @(negedge clk);
    end

    grant = 1'b0; pl_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout: packet len=%0d flits sent %0d want %0d", len, got, len + 1);
    end
    total++;
    if (sent_pl != len) begin
      bad++;
      $display("FAIL payload_consumed: got %0d want %0d", sent_pl, len);
    end
`ifdef INJ_STATS_EN
    if (done) pkts_done++;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; pkt_valid = 1'b0; pkt_dest = '0; pkt_len = '0;
    pl_valid = 1'b0; pl_data = '0; grant = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req, flit_valid, flit_id, length, flit_data, pkt_ready, pl_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b fv=%b id=%03b len=%0d data=%08h pkt_ready=%b pl_ready=%b want all 0",
               req, flit_valid, flit_id, length, flit_data, pkt_ready, pl_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (pkt_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ready: pkt_ready=%b want 0", pkt_ready);
    end
    @(negedge clk);
    total++;
    if (pkt_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: pkt_ready=%b want 1", pkt_ready);
    end
  endtask

  task automatic test_basic();
    int span; bit pl_seen;
    run_packet(4'd5, 3, -1, -1, 0, 0, -1, 0, span, pl_seen);
    total++;
    if (span != 3) begin
      bad++;
      $display("FAIL consecutive: header-to-tail span=%0d want 3", span);
    end
  endtask

  task automatic test_header_only();
    int span; bit pl_seen;
    run_packet(4'd9, 0, -1, -1, 0, 0, -1, 0, span, pl_seen);
    total++;
    if (pl_seen) begin
      bad++;
      $display("FAIL header_only_pl_ready: pl_ready pulsed=%b want 0", pl_seen);
    end
  endtask

  task automatic test_preempt();
    int span; bit pl_seen;
    run_packet(4'd2, 4, 3, -1, 3, 0, -1, 0, span, pl_seen);
    run_packet(4'd6, 2, -1, 2, 2, 0, -1, 0, span, pl_seen);
`ifdef INJ_STATS_EN
    total++;
    if (preempt_cnt !== 16'd2 || pkt_cnt !== 16'(pkts_done)) begin
      bad++;
      $display("FAIL stats_preempt: preempt_cnt=%0d pkt_cnt=%0d want 2 %0d",
               preempt_cnt, pkt_cnt, pkts_done);
    end
`endif
  endtask

  task automatic test_bubbles();
    int span; bit pl_seen;
    run_packet(4'd7, 5, -1, -1, 0, 0, 2, 2, span, pl_seen);
    total++;
    if (span != 7) begin
      bad++;
      $display("FAIL bubble_span: header-to-tail span=%0d want 7", span);
    end
  endtask

  task automatic test_random();
    int span; bit pl_seen; int len, dc;
    for (int k = 0; k < 15; k++) begin
      len = $urandom_range(20);
      dc  = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(len + 6));
      run_packet(DEST_W'($urandom), len, -1, dc, 1 + $urandom_range(3), 30, -1, 0,
                 span, pl_seen);
    end
  endtask

  task automatic test_saturation();
    int span; bit pl_seen;
    run_packet(4'd15, LEN_MAX, 1, -1, 2, 0, -1, 0, span, pl_seen);
  endtask

  task automatic test_reset_mid();
    pkt_valid = 1'b1; pkt_dest = 4'd3; pkt_len = LEN_W'(6); grant = 1'b0; pl_valid = 1'b0;
    @(negedge clk);
    pkt_valid = 1'b0; grant = 1'b1; pl_valid = 1'b1; pl_data = 32'h1234_5678;
    repeat (4) @(negedge clk);
    total++;
    if ({flit_valid, flit_id, req} !== {1'b1, FLIT_BODY, 1'b1}) begin
      bad++;
      $display("FAIL mid_body: fv=%b id=%03b req=%b want 1 100 1", flit_valid, flit_id, req);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({req, flit_valid, flit_id, length, flit_data, pkt_ready, pl_ready} !== '0) begin
      bad++;
      $display("FAIL reset_mid: req=%b fv=%b id=%03b len=%0d data=%08h pkt_ready=%b pl_ready=%b want all 0",
               req, flit_valid, flit_id, length, flit_data, pkt_ready, pl_ready);
    end
    rst = 1'b0; grant = 1'b0; pl_valid = 1'b0;
    #1;
    total++;
    if (pkt_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_release: pkt_ready=%b want 0", pkt_ready);
    end
    @(negedge clk);
    total++;
    if (pkt_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_ready: pkt_ready=%b want 1", pkt_ready);
    end
`ifdef INJ_STATS_EN
    pkts_done = 0;
`endif
  endtask

  task automatic test_back_to_back();
    int span; bit pl_seen;
    run_packet(4'd1, 2, -1, -1, 0, 0, -1, 0, span, pl_seen);
    run_packet(4'd4, 1, -1, -1, 0, 0, -1, 0, span, pl_seen);
`ifdef INJ_STATS_EN
    total++;
    if (pkt_cnt !== 16'(pkts_done)) begin
      bad++;
      $display("FAIL stats_pkt_cnt: pkt_cnt=%0d want %0d", pkt_cnt, pkts_done);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header_only();
    test_preempt();
    test_bubbles();
    test_random();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
